// File: rtl/stream_xbar_pkg.sv
// stream_xbar_pkg - shared types and helpers for the stream crossbar family.
// Rev 1.0
`default_nettype none

package stream_xbar_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SEND  = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_t;

  function automatic logic dest_in_range(input int unsigned dest, input int unsigned count);
    return (dest < count);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_out_reg.sv
// stream_out_reg - single-stage valid/ready output register holding an opaque payload.
// Rev 1.0
`default_nettype none

module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_load_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // The caller only loads when the slot is empty or being drained this cycle,
  // so a stalled beat is never overwritten.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (in_load_i) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/stream_pkt_tx.sv
// stream_pkt_tx - frames a descriptor plus raw payload into a dest/last stream for one crossbar input.
// Rev 1.0
`default_nettype none

module stream_pkt_tx
  import stream_xbar_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 8,
  parameter  int M_DATA_COUNT = 3,
  parameter  int LEN_WIDTH    = 8,
  parameter  int CNT_WIDTH    = 16,
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DEST_WIDTH-1:0] desc_dest_i,
  input  logic [LEN_WIDTH-1:0]    desc_len_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [T_DATA_WIDTH-1:0] pld_data_i,
  input  logic                    pld_valid_i,
  output logic                    pld_ready_o,
  output logic [T_DATA_WIDTH-1:0] s_data_o,
  output logic [T_DEST_WIDTH-1:0] s_dest_o,
  output logic                    s_last_o,
  output logic                    s_valid_o,
  input  logic                    s_ready_i,
  output logic                    busy_o,
  output logic                    err_dest_o,
  output logic [CNT_WIDTH-1:0]    pkt_cnt_o
);

  localparam int PAYLOAD_WIDTH = T_DATA_WIDTH + T_DEST_WIDTH + 1;

  tx_state_t             state_q, state_d;
  logic [T_DEST_WIDTH-1:0] dest_q, dest_d;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic                     load;
  logic                     pld_accept;
  logic                     desc_ok;
  logic                     last_beat;
  logic [PAYLOAD_WIDTH-1:0] reg_in;
  logic [PAYLOAD_WIDTH-1:0] reg_out;

  assign desc_ok   = dest_in_range(32'(desc_dest_i), M_DATA_COUNT);
  assign last_beat = (beats_q == '0);

  // desc_ready_o is qualified by rst_n so every output reads 0 while reset is held.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    beats_d      = beats_q;
    desc_ready_o = 1'b0;
    pld_ready_o  = 1'b0;
    err_dest_o   = 1'b0;
    load         = 1'b0;
    pld_accept   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        desc_ready_o = rst_n;
        if (desc_valid_i && rst_n) begin
          dest_d  = desc_dest_i;
          beats_d = desc_len_i;
          if (desc_ok) begin
            state_d = TX_SEND;
          end else begin
            err_dest_o = 1'b1;
            state_d    = TX_DRAIN;
          end
        end
      end
      TX_SEND: begin
        pld_ready_o = !s_valid_o || s_ready_i;
        pld_accept  = pld_valid_i && (!s_valid_o || s_ready_i);
        load        = pld_accept;
      end
      TX_DRAIN: begin
        pld_ready_o = 1'b1;
        pld_accept  = pld_valid_i;
      end
      default: state_d = TX_IDLE;
    endcase

    if (pld_accept) begin
      if (last_beat) begin
        state_d = TX_IDLE;
      end else begin
        beats_d = beats_q - LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (s_valid_o && s_ready_i && s_last_o) begin
      pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      dest_q    <= '0;
      beats_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      beats_q   <= beats_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign reg_in = {dest_q, pld_data_i, last_beat};

  stream_out_reg #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data_i  (reg_in),
    .in_load_i  (load),
    .out_data_o (reg_out),
    .out_valid_o(s_valid_o),
    .out_ready_i(s_ready_i)
  );

  assign s_dest_o  = reg_out[PAYLOAD_WIDTH-1 -: T_DEST_WIDTH];
  assign s_data_o  = reg_out[T_DATA_WIDTH:1];
  assign s_last_o  = reg_out[0];
  assign busy_o    = (state_q != TX_IDLE);
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_pkt_tx.sv
// tb_stream_pkt_tx - directed self-checking bench for stream_pkt_tx.
// Rev 1.0
`default_nettype none

module tb_stream_pkt_tx;

  localparam int DW  = 8;
  localparam int M   = 3;
  localparam int LW  = 8;
  localparam int CW  = 16;
  localparam int DSW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DSW-1:0] desc_dest_i;
  logic [LW-1:0]  desc_len_i;
  logic           desc_valid_i;
  logic           desc_ready_o;
  logic [DW-1:0]  pld_data_i;
  logic           pld_valid_i;
  logic           pld_ready_o;
  logic [DW-1:0]  s_data_o;
  logic [DSW-1:0] s_dest_o;
  logic           s_last_o;
  logic           s_valid_o;
  logic           s_ready_i;
  logic           busy_o;
  logic           err_dest_o;
  logic [CW-1:0]  pkt_cnt_o;

  // Narrow-counter twin driven by the same inputs; only its counter is checked.
  logic           n_desc_ready, n_pld_ready, n_last, n_valid, n_busy, n_err;
  logic [DW-1:0]  n_data;
  logic [DSW-1:0] n_dest;
  logic [3:0]     n_pkt_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  stream_pkt_tx #(
    .T_DATA_WIDTH(DW), .M_DATA_COUNT(M), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_dest_i(desc_dest_i), .desc_len_i(desc_len_i), .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o),
    .pld_data_i(pld_data_i), .pld_valid_i(pld_valid_i), .pld_ready_o(pld_ready_o),
    .s_data_o(s_data_o), .s_dest_o(s_dest_o), .s_last_o(s_last_o), .s_valid_o(s_valid_o),
    .s_ready_i(s_ready_i),
    .busy_o(busy_o), .err_dest_o(err_dest_o), .pkt_cnt_o(pkt_cnt_o)
  );

  stream_pkt_tx #(
    .T_DATA_WIDTH(DW), .M_DATA_COUNT(M), .LEN_WIDTH(LW), .CNT_WIDTH(4)
  ) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .desc_dest_i(desc_dest_i), .desc_len_i(desc_len_i), .desc_valid_i(desc_valid_i),
    .desc_ready_o(n_desc_ready),
    .pld_data_i(pld_data_i), .pld_valid_i(pld_valid_i), .pld_ready_o(n_pld_ready),
    .s_data_o(n_data), .s_dest_o(n_dest), .s_last_o(n_last), .s_valid_o(n_valid),
    .s_ready_i(s_ready_i),
    .busy_o(n_busy), .err_dest_o(n_err), .pkt_cnt_o(n_pkt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] data, input logic [1:0] dest,
                            input logic last);
    check({tag, "_valid"}, 32'(s_valid_o), 32'(1));
    check({tag, "_data"},  32'(s_data_o),  32'(data));
    check({tag, "_dest"},  32'(s_dest_o),  32'(dest));
    check({tag, "_last"},  32'(s_last_o),  32'(last));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_valid"},    32'(s_valid_o),    32'(0));
    check({tag, "_s_data"},     32'(s_data_o),     32'(0));
    check({tag, "_s_dest"},     32'(s_dest_o),     32'(0));
    check({tag, "_s_last"},     32'(s_last_o),     32'(0));
    check({tag, "_busy"},       32'(busy_o),       32'(0));
    check({tag, "_desc_ready"}, 32'(desc_ready_o), 32'(0));
    check({tag, "_pld_ready"},  32'(pld_ready_o),  32'(0));
    check({tag, "_err_dest"},   32'(err_dest_o),   32'(0));
    check({tag, "_pkt_cnt"},    32'(pkt_cnt_o),    32'(0));
  endtask

  task automatic send_single(input logic [1:0] dest, input logic [7:0] data);
    desc_dest_i  = dest;
    desc_len_i   = '0;
    desc_valid_i = 1'b1;
    pld_valid_i  = 1'b0;
    tick();
    desc_valid_i = 1'b0;
    pld_data_i   = data;
    pld_valid_i  = 1'b1;
    tick();
    check_beat("single", data, dest, 1'b1);
    pld_valid_i = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    desc_dest_i  = '0;
    desc_len_i   = '0;
    desc_valid_i = 1'b0;
    pld_data_i   = '0;
    pld_valid_i  = 1'b0;
    s_ready_i    = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_reset_desc_ready", 32'(desc_ready_o), 32'(1));
    check("post_reset_busy",       32'(busy_o),       32'(0));

    // Packet dest=2 len=3 at full throughput
    desc_dest_i  = 2'd2;
    desc_len_i   = 8'd3;
    desc_valid_i = 1'b1;
    s_ready_i    = 1'b1;
    #1;
    check("t1_desc_ready", 32'(desc_ready_o), 32'(1));
    check("t1_err",        32'(err_dest_o),   32'(0));
    tick();
    desc_valid_i = 1'b0;
    check("t1_busy", 32'(busy_o), 32'(1));
    check("t1_desc_ready_send", 32'(desc_ready_o), 32'(0));
    for (int i = 0; i < 4; i++) begin
      pld_data_i  = 8'(8'hA0 + i);
      pld_valid_i = 1'b1;
      #1;
      check("t1_pld_ready", 32'(pld_ready_o), 32'(1));
      tick();
      check_beat("t1_beat", 8'(8'hA0 + i), 2'd2, (i == 3));
    end
    pld_valid_i = 1'b0;
    check("t1_cnt_before", 32'(pkt_cnt_o), 32'(0));
    check("t1_busy_end",   32'(busy_o),    32'(0));
    tick();
    check("t1_valid_clear", 32'(s_valid_o), 32'(0));
    check("t1_cnt_after",   32'(pkt_cnt_o), 32'(1));

    // Same packet with a 3-cycle output stall on the second beat
    desc_dest_i  = 2'd2;
    desc_len_i   = 8'd3;
    desc_valid_i = 1'b1;
    tick();
    desc_valid_i = 1'b0;
    pld_data_i   = 8'hA0;
    pld_valid_i  = 1'b1;
    tick();
    check_beat("t2_b0", 8'hA0, 2'd2, 1'b0);
    pld_data_i = 8'hA1;
    tick();
    check_beat("t2_b1", 8'hA1, 2'd2, 1'b0);
    pld_data_i = 8'hA2;
    s_ready_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_stall_pld_ready", 32'(pld_ready_o), 32'(0));
      tick();
      check_beat("t2_hold", 8'hA1, 2'd2, 1'b0);
    end
    s_ready_i = 1'b1;
    #1;
    check("t2_resume_pld_ready", 32'(pld_ready_o), 32'(1));
    tick();
    check_beat("t2_b2", 8'hA2, 2'd2, 1'b0);
    pld_data_i = 8'hA3;
    tick();
    check_beat("t2_b3", 8'hA3, 2'd2, 1'b1);
    pld_valid_i = 1'b0;
    check("t2_cnt_before", 32'(pkt_cnt_o), 32'(1));
    tick();
    check("t2_valid_clear", 32'(s_valid_o), 32'(0));
    check("t2_cnt_after",   32'(pkt_cnt_o), 32'(2));

    // Invalid destination: drained, flagged, not counted
    desc_dest_i  = 2'd3;
    desc_len_i   = 8'd1;
    desc_valid_i = 1'b1;
    #1;
    check("t3_err_pulse", 32'(err_dest_o), 32'(1));
    tick();
    desc_valid_i = 1'b0;
    check("t3_err_clear", 32'(err_dest_o), 32'(0));
    check("t3_busy",      32'(busy_o),     32'(1));
    pld_data_i  = 8'h55;
    pld_valid_i = 1'b1;
    #1;
    check("t3_pld_ready", 32'(pld_ready_o), 32'(1));
    tick();
    check("t3_valid0", 32'(s_valid_o), 32'(0));
    check("t3_busy_mid", 32'(busy_o), 32'(1));
    pld_data_i = 8'h66;
    tick();
    check("t3_valid1",  32'(s_valid_o), 32'(0));
    check("t3_idle",    32'(busy_o),    32'(0));
    check("t3_cnt",     32'(pkt_cnt_o), 32'(2));
    pld_valid_i = 1'b0;

    // Back-to-back single-beat packets with one bubble between them
    desc_dest_i  = 2'd0;
    desc_len_i   = 8'd0;
    desc_valid_i = 1'b1;
    tick();
    desc_dest_i = 2'd1;
    pld_data_i  = 8'h11;
    pld_valid_i = 1'b1;
    #1;
    check("t4_desc_ready_send", 32'(desc_ready_o), 32'(0));
    check("t4_pld_ready_p0",    32'(pld_ready_o),  32'(1));
    tick();
    check_beat("t4_p0", 8'h11, 2'd0, 1'b1);
    pld_data_i = 8'h22;
    #1;
    check("t4_bubble_pld_ready", 32'(pld_ready_o),  32'(0));
    check("t4_bubble_desc_rdy",  32'(desc_ready_o), 32'(1));
    tick();
    desc_valid_i = 1'b0;
    check("t4_gap_valid", 32'(s_valid_o), 32'(0));
    check("t4_cnt_mid",   32'(pkt_cnt_o), 32'(3));
    tick();
    check_beat("t4_p1", 8'h22, 2'd1, 1'b1);
    pld_valid_i = 1'b0;
    tick();
    check("t4_cnt_end", 32'(pkt_cnt_o), 32'(4));

    // Asynchronous reset in the middle of a packet
    desc_dest_i  = 2'd1;
    desc_len_i   = 8'd3;
    desc_valid_i = 1'b1;
    tick();
    desc_valid_i = 1'b0;
    pld_data_i   = 8'hB0;
    pld_valid_i  = 1'b1;
    tick();
    pld_data_i = 8'hB1;
    tick();
    check_beat("t5_b1", 8'hB1, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t5_async");
    check("t5_narrow_cnt", 32'(n_pkt_cnt), 32'(0));
    pld_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t5_idle_after", 32'(busy_o),       32'(0));
    check("t5_desc_ready", 32'(desc_ready_o), 32'(1));
    desc_dest_i  = 2'd0;
    desc_len_i   = 8'd1;
    desc_valid_i = 1'b1;
    tick();
    desc_valid_i = 1'b0;
    pld_data_i   = 8'hC0;
    pld_valid_i  = 1'b1;
    tick();
    check_beat("t5_c0", 8'hC0, 2'd0, 1'b0);
    pld_data_i = 8'hC1;
    tick();
    check_beat("t5_c1", 8'hC1, 2'd0, 1'b1);
    pld_valid_i = 1'b0;
    tick();
    check("t5_cnt", 32'(pkt_cnt_o), 32'(1));

    // Counter wrap on the 4-bit twin; wide counter keeps climbing
    for (int i = 0; i < 14; i++) begin
      send_single(2'(i % 3), 8'(8'h30 + i));
    end
    check("t6_narrow_full", 32'(n_pkt_cnt), 32'(15));
    check("t6_wide_15",     32'(pkt_cnt_o), 32'(15));
    send_single(2'd2, 8'hEE);
    check("t6_narrow_wrap", 32'(n_pkt_cnt), 32'(0));
    check("t6_wide_16",     32'(pkt_cnt_o), 32'(16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
